// File: rtl/alu_main.sv
// 8-bit ALU with latched operands and a LOAD/EXEC/HOLD control loop.
// Operands are captured when leaving LOAD and the result is written when leaving EXEC.
module alu_main (
   input  logic       clk,
   input  logic       rst,
   input  logic       on,
   input  logic [2:0] in_sel,
   input  logic [7:0] num1,
   input  logic [7:0] num2,
   input  logic [6:0] out_sel,
   output logic [7:0] final1,
   output logic [7:0] final2,
   output logic [7:0] out,
   output logic [1:0] currState,
   output logic [1:0] nextState
);

   localparam int unsigned W  = 8;
   localparam int unsigned PW = 2 * W;

   typedef enum logic [1:0] {
      S_OFF  = 2'b00,
      S_LOAD = 2'b01,
      S_EXEC = 2'b10,
      S_HOLD = 2'b11
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   final1_q, final1_d;
   logic [W-1:0]   final2_q, final2_d;
   logic [W-1:0]   out_q, out_d;
   logic [PW-1:0]  prod_c;
   logic [W-1:0]   result_c;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_OFF;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; dropping the enable always returns to OFF
   always_comb begin
      state_d = S_OFF;
      if (on) begin
         case (state_q)
            S_OFF:   state_d = S_LOAD;
            S_LOAD:  state_d = S_EXEC;
            S_EXEC:  state_d = S_HOLD;
            S_HOLD:  state_d = S_LOAD;
            default: state_d = S_OFF;
         endcase
      end
   end

   // Operation decode; anything other than a single hot bit yields zero
   assign prod_c = PW'(final1_q) * PW'(final2_q);

   always_comb begin
      result_c = '0;
      case (out_sel)
         7'b1000000: result_c = final1_q + final2_q;
         7'b0100000: result_c = final1_q - final2_q;
         7'b0010000: result_c = W'(prod_c);
         7'b0001000: result_c = final1_q & final2_q;
         7'b0000100: result_c = final1_q | final2_q;
         7'b0000010: result_c = final1_q ^ final2_q;
         7'b0000001: result_c = ~final1_q;
         default:    result_c = '0;
      endcase
   end

   // Output/data next-values: capture only when leaving LOAD, compute only when leaving EXEC
   always_comb begin
      final1_d = final1_q;
      final2_d = final2_q;
      out_d    = out_q;
      if (on) begin
         case (state_q)
            S_LOAD: begin
               if (in_sel[0]) begin
                  final1_d = '0;
                  final2_d = '0;
               end else if (in_sel[1]) begin
                  final1_d = num1;
                  final2_d = num2;
               end
            end
            S_EXEC:  out_d = result_c;
            default: ;
         endcase
      end
   end

   // Data registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         final1_q <= '0;
         final2_q <= '0;
         out_q    <= '0;
      end else begin
         final1_q <= final1_d;
         final2_q <= final2_d;
         out_q    <= out_d;
      end
   end

   assign final1    = final1_q;
   assign final2    = final2_q;
   assign out       = out_q;
   assign currState = state_q;
   assign nextState = state_d;

endmodule

// File: tb/tb_alu_main.sv
// Bench for alu_main: behavioural model checked every cycle plus directed literal checks.
module tb_alu_main;

   logic       clk;
   logic       rst;
   logic       on;
   logic [2:0] in_sel;
   logic [7:0] num1;
   logic [7:0] num2;
   logic [6:0] out_sel;
   logic [7:0] final1;
   logic [7:0] final2;
   logic [7:0] out;
   logic [1:0] currState;
   logic [1:0] nextState;

   int total = 0;
   int bad   = 0;

   alu_main dut (
      .clk       (clk),
      .rst       (rst),
      .on        (on),
      .in_sel    (in_sel),
      .num1      (num1),
      .num2      (num2),
      .out_sel   (out_sel),
      .final1    (final1),
      .final2    (final2),
      .out       (out),
      .currState (currState),
      .nextState (nextState)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: phase 0=OFF 1=LOAD 2=EXEC 3=HOLD, operands and result as plain integers
   int m_phase = 0;
   int m_a     = 0;
   int m_b     = 0;
   int m_out   = 0;

   function automatic int alu_fn(input int sel, input int a, input int b);
      if ($countones(7'(sel)) != 1) return 0;
      if (sel == 64) return (a + b) % 256;
      if (sel == 32) return (a - b + 256) % 256;
      if (sel == 16) return (a * b) % 256;
      if (sel == 8)  return a & b;
      if (sel == 4)  return a | b;
      if (sel == 2)  return a ^ b;
      return 255 - a;
   endfunction

   function automatic int model_next();
      if (!on) return 0;
      if (m_phase == 3) return 1;
      return m_phase + 1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_phase = 0; m_a = 0; m_b = 0; m_out = 0;
      end else begin
         if (on && m_phase == 1) begin
            if (in_sel[0]) begin
               m_a = 0; m_b = 0;
            end else if (in_sel[1]) begin
               m_a = int'(num1); m_b = int'(num2);
            end
         end
         if (on && m_phase == 2) m_out = alu_fn(int'(out_sel), m_a, m_b);
         m_phase = model_next();
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("m_state",  int'(currState), m_phase);
      chk("m_next",   int'(nextState), model_next());
      chk("m_final1", int'(final1),    m_a);
      chk("m_final2", int'(final2),    m_b);
      chk("m_out",    int'(out),       m_out);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic loop3();
      step(); step(); step();
   endtask

   logic [6:0] op_sel [7];
   int         op_exp [7];

   initial begin
      op_sel[0] = 7'b0100000; op_exp[0] = 61;
      op_sel[1] = 7'b0010000; op_exp[1] = 214;
      op_sel[2] = 7'b0001000; op_exp[2] = 8'h12;
      op_sel[3] = 7'b0000100; op_exp[3] = 8'h5F;
      op_sel[4] = 7'b0000010; op_exp[4] = 8'h4D;
      op_sel[5] = 7'b0000001; op_exp[5] = 8'hA8;
      op_sel[6] = 7'b0000011; op_exp[6] = 0;

      rst = 1'b0; on = 1'b1; in_sel = 3'b010;
      num1 = 8'h57; num2 = 8'h1A; out_sel = 7'b1000000;
      #13;
      chk("rst_state",  int'(currState), 0);
      chk("rst_next",   int'(nextState), 1);
      chk("rst_final1", int'(final1),    0);
      chk("rst_final2", int'(final2),    0);
      chk("rst_out",    int'(out),       0);

      #9 rst = 1'b1;
      step();
      chk("e1_state", int'(currState), 1);
      step();
      chk("e2_final1", int'(final1), 87);
      chk("e2_final2", int'(final2), 26);
      chk("e2_state",  int'(currState), 2);
      step();
      chk("e3_out",   int'(out), 113);
      chk("e3_state", int'(currState), 3);

      for (int i = 0; i < 7; i++) begin
         out_sel = op_sel[i];
         loop3();
         chk($sformatf("op%0d_out", i), int'(out), op_exp[i]);
      end

      // Persist keeps earlier operands
      in_sel = 3'b100; num1 = 8'h11; num2 = 8'h22; out_sel = 7'b1000000;
      loop3();
      chk("persist_final1", int'(final1), 87);
      chk("persist_out",    int'(out),    113);

      // Clear wins
      in_sel = 3'b011;
      loop3();
      chk("clear_final1", int'(final1), 0);
      chk("clear_out",    int'(out),    0);

      // Mid-run reset
      in_sel = 3'b010; num1 = 8'd2; num2 = 8'd4;
      step();
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_state", int'(currState), 0);
      chk("mid_rst_final", int'(final1),    0);
      @(negedge clk);
      #2 rst = 1'b1;
      loop3();
      chk("reload_out", int'(out), 6);
      out_sel = 7'b0100000;
      loop3();
      chk("sub_wrap_out", int'(out), 254);

      // Enable dropped in HOLD
      on = 1'b0;
      #1 chk("off_next", int'(nextState), 0);
      step();
      chk("off_state", int'(currState), 0);
      chk("off_out",   int'(out), 254);
      chk("off_final", int'(final1), 2);
      num1 = 8'd10; num2 = 8'd3; on = 1'b1;
      loop3();
      chk("resume_state", int'(currState), 3);
      chk("resume_out",   int'(out), 7);

      // Enable dropped in EXEC: no result write
      step(); step();
      out_sel = 7'b1000000; on = 1'b0;
      step();
      chk("exec_drop_out", int'(out), 7);
      on = 1'b1;
      loop3();
      chk("exec_drop_resume", int'(out), 13);

      // Enable dropped in LOAD: no capture
      step();
      num1 = 8'd50; on = 1'b0;
      step();
      chk("load_drop_final", int'(final1), 10);
      on = 1'b1;
      loop3();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
